// File: rtl/byte_fifo_sync_if.sv
// Byte FIFO handshake bundle.
// Writer, reader, status and error-flag signals.
interface byte_fifo_sync_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [DW-1:0] d_in;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] d_out;
  logic          empty;
  logic [AW:0]   count;
  logic          clr_flags;
  logic          ovf;
  logic          unf;

  modport master (
    output wr_en, d_in, rd_en, clr_flags,
    input  full, d_out, empty, count, ovf, unf
  );

  modport slave (
    input  wr_en, d_in, rd_en, clr_flags,
    output full, d_out, empty, count, ovf, unf
  );
endinterface

// File: rtl/byte_fifo_sync.sv
// Single-clock FWFT byte FIFO with sticky
// overflow/underflow flags.
module byte_fifo_sync #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  byte_fifo_sync_if.slave   f
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf_q;
  logic          unf_q;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  assign full_w  = (cnt == (AW+1)'(DEPTH));
  assign empty_w = (cnt == '0);

  // A full FIFO still takes a write when a pop frees a slot.
  assign wr_acc = f.wr_en & (~full_w | f.rd_en);
  assign rd_acc = f.rd_en & ~empty_w;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= f.d_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt <= cnt + 1'b1;
        rd_acc & ~wr_acc: cnt <= cnt - 1'b1;
        default:          cnt <= cnt;
      endcase
      // Set wins over a same-cycle clear.
      ovf_q <= (f.wr_en & ~wr_acc)
             | (ovf_q & ~f.clr_flags);
      unf_q <= (f.rd_en & empty_w)
             | (unf_q & ~f.clr_flags);
    end
  end

  assign f.d_out = empty_w ? '0 : mem[rd_ptr];
  assign f.full  = full_w;
  assign f.empty = empty_w;
  assign f.count = cnt;
  assign f.ovf   = ovf_q;
  assign f.unf   = unf_q;

endmodule

// File: tb/tb_byte_fifo_sync.sv
// Bench for byte_fifo_sync: directed scenarios
// plus random push/pop against a queue model.
module tb_byte_fifo_sync;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  byte_fifo_sync_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  byte_fifo_sync #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .f   (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  function automatic logic [7:0] m_head();
    return (q.size() == 0) ? 8'h00 : q[0];
  endfunction

  function automatic logic [AW:0] m_cnt();
    return (AW+1)'(q.size());
  endfunction

  function automatic logic m_empty();
    return q.size() == 0;
  endfunction

  function automatic logic m_full();
    return q.size() == DEPTH;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one clock of stimulus and advance the model.
  task automatic cycle(bit we, logic [7:0] din,
                       bit re, bit clr);
    bit e, fl, wa, ra;
    bus.wr_en     = we;
    bus.d_in      = din;
    bus.rd_en     = re;
    bus.clr_flags = clr;
    e  = (q.size() == 0);
    fl = (q.size() == DEPTH);
    ra = re && !e;
    wa = we && (!fl || re);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (we && !wa) m_ovf = 1'b1;
    if (re && e)   m_unf = 1'b1;
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(din);
    @(posedge clk);
    #1;
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b want=0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errs++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    checks++; if (bus.d_out !== 8'h00) begin errs++; $display("FAIL reset_dout got=%h want=00", bus.d_out); end
    checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    checks++; if (bus.unf !== 1'b0) begin errs++; $display("FAIL reset_unf got=%b want=0", bus.unf); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      checks++; if (bus.count !== 4'(i)) begin errs++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, bus.count, i); end
      checks++; if (bus.d_out !== 8'h01) begin errs++; $display("FAIL fill_head i=%0d got=%h want=01", i, bus.d_out); end
    end
    checks++; if (bus.full !== 1'b1) begin errs++; $display("FAIL fill_full got=%b want=1", bus.full); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (bus.d_out !== 8'(i)) begin errs++; $display("FAIL drain_data i=%0d got=%h want=%h", i, bus.d_out, 8'(i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL drain_empty got=%b want=1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errs++; $display("FAIL drain_count got=%0d want=0", bus.count); end
    checks++; if (bus.unf !== 1'b0) begin errs++; $display("FAIL drain_unf got=%b want=0", bus.unf); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'($urandom_range(0, 8'h9f)), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got=%b want=1", bus.ovf); end
    checks++; if (bus.count !== 4'd8) begin errs++; $display("FAIL ovf_count got=%0d want=8", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.d_out !== m_head()) begin errs++; $display("FAIL ovf_data i=%0d got=%h want=%h", i, bus.d_out, m_head()); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL ovf_clr got=%b want=0", bus.ovf); end
  endtask

  task automatic test_underflow_write();
    cycle(1'b1, 8'h5C, 1'b1, 1'b0);
    checks++; if (bus.unf !== 1'b1) begin errs++; $display("FAIL unf_set got=%b want=1", bus.unf); end
    checks++; if (bus.count !== 4'd1) begin errs++; $display("FAIL unf_count got=%0d want=1", bus.count); end
    checks++; if (bus.d_out !== 8'h5C) begin errs++; $display("FAIL unf_dout got=%h want=5c", bus.d_out); end
    // Set must win over a simultaneous clear.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (bus.unf !== 1'b0) begin errs++; $display("FAIL unf_clr got=%b want=0", bus.unf); end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (bus.unf !== 1'b1) begin errs++; $display("FAIL unf_set_prio got=%b want=1", bus.unf); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.unf !== m_unf) begin errs++; $display("FAIL unf_final got=%b want=%b", bus.unf, m_unf); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h18, 1'b1, 1'b0);
    checks++; if (bus.count !== 4'd8) begin errs++; $display("FAIL frw_count got=%0d want=8", bus.count); end
    checks++; if (bus.d_out !== 8'h11) begin errs++; $display("FAIL frw_dout got=%h want=11", bus.d_out); end
    checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL frw_ovf got=%b want=0", bus.ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.d_out !== 8'(8'h11 + i)) begin errs++; $display("FAIL frw_drain i=%0d got=%h want=%h", i, bus.d_out, 8'(8'h11 + i)); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    bit we, re, clr;
    for (int n = 0; n < 40; n++) begin
      we  = ($urandom_range(0, 9) < 6);
      re  = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 7) == 0);
      cycle(we, 8'($urandom), re, clr);
      checks++; if (bus.d_out !== m_head()) begin errs++; $display("FAIL rnd_dout n=%0d got=%h want=%h", n, bus.d_out, m_head()); end
      checks++; if (bus.count !== m_cnt()) begin errs++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.count, m_cnt()); end
      checks++; if (bus.full !== m_full()) begin errs++; $display("FAIL rnd_full n=%0d got=%b want=%b", n, bus.full, m_full()); end
      checks++; if (bus.empty !== m_empty()) begin errs++; $display("FAIL rnd_empty n=%0d got=%b want=%b", n, bus.empty, m_empty()); end
      checks++; if (bus.ovf !== m_ovf) begin errs++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, bus.ovf, m_ovf); end
      checks++; if (bus.unf !== m_unf) begin errs++; $display("FAIL rnd_unf n=%0d got=%b want=%b", n, bus.unf, m_unf); end
    end
    while (q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (bus.count !== 4'd5) begin errs++; $display("FAIL ar_pre_count got=%0d want=5", bus.count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 4'd0) begin errs++; $display("FAIL ar_count got=%0d want=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL ar_empty got=%b want=1", bus.empty); end
    checks++; if (bus.d_out !== 8'h00) begin errs++; $display("FAIL ar_dout got=%h want=00", bus.d_out); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (bus.d_out !== 8'h3C) begin errs++; $display("FAIL ar_readback got=%h want=3c", bus.d_out); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL ar_final_empty got=%b want=1", bus.empty); end
  endtask

  initial begin
    bus.wr_en     = 1'b0;
    bus.d_in      = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clr_flags = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_write();
    test_full_rw();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
